// File: rtl/vga_sprite_overlay_n.sv
// Purpose : N-sprite 8x8 1bpp overlay between the VGA timing generator and the RGB222 output register.
// Latency : 2 clocks from de/hpos/vpos/bg_rgb to pix_rgb/pix_hit; 1 pixel per clock.
// Backpressure: none; free-running pixel pipeline, never stalls or flushes.
//
// Ports:
//   clk, rst_n        pixel clock, async active-low reset (release already synchronised to clk)
//   cfg_we/addr/data  byte-wide shadow register writes, addr = {sprite index, 4-bit offset}
//   frame_start       commits shadow set to active set, latches/clears collision flags
//   de, hpos, vpos    raster position and display enable
//   bg_rgb            background pixel
//   pix_rgb, pix_hit  composited pixel and "sprite drawn here" flag
//   coll_status       per-sprite collision flags of the previous frame
module vga_sprite_overlay_n #(
    parameter  int NSPR = 4,
    parameter  int HW   = 10,
    localparam int AW   = $clog2(NSPR) + 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [7:0]      cfg_data,
    input  logic            frame_start,
    input  logic            de,
    input  logic [HW-1:0]   hpos,
    input  logic [HW-1:0]   vpos,
    input  logic [5:0]      bg_rgb,
    output logic [5:0]      pix_rgb,
    output logic            pix_hit,
    output logic [NSPR-1:0] coll_status
);

    typedef struct packed {
        logic [HW-1:0] x;
        logic [HW-1:0] y;
        logic [5:0]    colour;
        logic          scale2x;
        logic          hflip;
        logic          en;
        logic [63:0]   bmp;     // row r in bits [8r+7:8r]
    } spr_t;

    // ---------------- configuration: shadow and active sets ----------------
    spr_t [NSPR-1:0] shadow_q, shadow_d;
    spr_t [NSPR-1:0] active_q, active_d;
    logic [7:0]      wr_idx;
    logic [3:0]      wr_off;

    always_comb begin
        shadow_d = shadow_q;
        wr_idx   = 8'(cfg_addr >> 4);
        wr_off   = cfg_addr[3:0];
        // Indices >= NSPR match no sprite, so such writes simply fall away.
        for (int i = 0; i < NSPR; i++) begin
            if (cfg_we && (wr_idx == 8'(i))) begin
                case (wr_off)
                    4'd0: shadow_d[i].x[7:0]    = cfg_data;
                    4'd1: shadow_d[i].x[HW-1:8] = cfg_data[HW-9:0];
                    4'd2: shadow_d[i].y[7:0]    = cfg_data;
                    4'd3: shadow_d[i].y[HW-1:8] = cfg_data[HW-9:0];
                    4'd4: shadow_d[i].colour    = cfg_data[5:0];
                    4'd5: {shadow_d[i].scale2x, shadow_d[i].hflip, shadow_d[i].en} = cfg_data[2:0];
                    4'd6, 4'd7: ;
                    default: shadow_d[i].bmp[{wr_off[2:0], 3'b000} +: 8] = cfg_data;
                endcase
            end
        end
    end

    // The commit copies the shadow as it was before this cycle's write, so a
    // write coinciding with frame_start only becomes visible one frame later.
    always_comb begin
        active_d = frame_start ? shadow_q : active_q;
    end

    // ---------------- stage 1: in-box test and bitmap offsets ----------------
    logic                  s1_de_q, s1_de_d;
    logic [5:0]            s1_bg_q, s1_bg_d;
    logic [NSPR-1:0]       s1_in_q, s1_in_d;
    logic [NSPR-1:0][2:0]  s1_row_q, s1_row_d;
    logic [NSPR-1:0][2:0]  s1_col_q, s1_col_d;
    logic [HW:0]           dx, dy, fsz;

    // Compare in HW+1 bits so a sprite straddling the right/bottom edge is
    // clipped rather than wrapping round to coordinate 0.
    always_comb begin
        s1_de_d  = de;
        s1_bg_d  = bg_rgb;
        s1_in_d  = '0;
        s1_row_d = '0;
        s1_col_d = '0;
        dx       = '0;
        dy       = '0;
        fsz      = '0;
        for (int i = 0; i < NSPR; i++) begin
            dx  = {1'b0, hpos} - {1'b0, active_q[i].x};
            dy  = {1'b0, vpos} - {1'b0, active_q[i].y};
            fsz = active_q[i].scale2x ? (HW+1)'(16) : (HW+1)'(8);
            s1_in_d[i] = (hpos >= active_q[i].x) && (dx < fsz) &&
                         (vpos >= active_q[i].y) && (dy < fsz);
            s1_col_d[i] = active_q[i].scale2x ? dx[3:1] : dx[2:0];
            s1_row_d[i] = active_q[i].scale2x ? dy[3:1] : dy[2:0];
        end
    end

    // ---------------- stage 2: bitmap select, priority, collisions ----------------
    logic [5:0]      pix_rgb_q, pix_rgb_d;
    logic            pix_hit_q, pix_hit_d;
    logic [NSPR-1:0] acc_q, acc_d;
    logic [NSPR-1:0] coll_q, coll_d;
    logic [NSPR-1:0] spr_on, others, coll_now;
    logic [7:0]      row_byte;
    logic [5:0]      win_colour;
    logic            any_on;

    always_comb begin
        spr_on     = '0;
        others     = '0;
        coll_now   = '0;
        row_byte   = '0;
        win_colour = '0;
        any_on     = 1'b0;
        for (int i = 0; i < NSPR; i++) begin
            row_byte  = active_q[i].bmp[{s1_row_q[i], 3'b000} +: 8];
            // Without hflip, bit 7 is leftmost: index = 7 - col = col ^ 3'b111.
            spr_on[i] = s1_in_q[i] && active_q[i].en &&
                        row_byte[s1_col_q[i] ^ {3{~active_q[i].hflip}}];
        end
        // Walk from highest to lowest index so the lowest index wins.
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (spr_on[i]) begin
                win_colour = active_q[i].colour;
                any_on     = 1'b1;
            end
        end
        for (int i = 0; i < NSPR; i++) begin
            others      = spr_on;
            others[i]   = 1'b0;
            coll_now[i] = s1_de_q && spr_on[i] && (|others);
        end

        pix_hit_d = s1_de_q && any_on;
        if (!s1_de_q)    pix_rgb_d = '0;
        else if (any_on) pix_rgb_d = win_colour;
        else             pix_rgb_d = s1_bg_q;

        // A collision in the frame_start cycle itself still belongs to the
        // frame being closed.
        acc_d  = frame_start ? '0 : (acc_q | coll_now);
        coll_d = frame_start ? (acc_q | coll_now) : coll_q;
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            s1_de_q   <= 1'b0;
            s1_bg_q   <= '0;
            s1_in_q   <= '0;
            s1_row_q  <= '0;
            s1_col_q  <= '0;
            pix_rgb_q <= '0;
            pix_hit_q <= 1'b0;
            acc_q     <= '0;
            coll_q    <= '0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            s1_de_q   <= s1_de_d;
            s1_bg_q   <= s1_bg_d;
            s1_in_q   <= s1_in_d;
            s1_row_q  <= s1_row_d;
            s1_col_q  <= s1_col_d;
            pix_rgb_q <= pix_rgb_d;
            pix_hit_q <= pix_hit_d;
            acc_q     <= acc_d;
            coll_q    <= coll_d;
        end
    end

    assign pix_rgb     = pix_rgb_q;
    assign pix_hit     = pix_hit_q;
    assign coll_status = coll_q;

endmodule

// File: tb/tb_vga_sprite_overlay_n.sv
// Purpose : scoreboard bench for vga_sprite_overlay_n (NSPR=3 so an out-of-range index exists).
// Latency : expected pixel results are queued at drive time and popped 2 clocks later.
// Backpressure: none; a delayed valid tag marks which output cycles carry a check.
module tb_vga_sprite_overlay_n;
    localparam int NSPR = 3;
    localparam int HW   = 10;
    localparam int AW   = $clog2(NSPR) + 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [7:0]      cfg_data;
    logic            frame_start;
    logic            de;
    logic [HW-1:0]   hpos, vpos;
    logic [5:0]      bg_rgb;
    logic [5:0]      pix_rgb;
    logic            pix_hit;
    logic [NSPR-1:0] coll_status;

    vga_sprite_overlay_n #(.NSPR(NSPR), .HW(HW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .frame_start(frame_start), .de(de),
        .hpos(hpos), .vpos(vpos), .bg_rgb(bg_rgb), .pix_rgb(pix_rgb),
        .pix_hit(pix_hit), .coll_status(coll_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            chk_pix;
        logic [5:0]      rgb;
        logic            hit;
        logic            chk_coll;
        logic [NSPR-1:0] coll;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic drv_vld, vld_d1, vld_d2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Valid tag follows the DUT's two register stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_d1 <= 1'b0;
            vld_d2 <= 1'b0;
        end else begin
            vld_d1 <= drv_vld;
            vld_d2 <= vld_d1;
        end
    end

    // Monitor: pops one expectation for each tagged output cycle.
    always @(negedge clk) begin
        if (vld_d2) begin
            if (q.size() == 0) begin
                check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.chk_pix) begin
                    check("pix_rgb", 32'(pix_rgb), 32'(mon_e.rgb));
                    check("pix_hit", 32'(pix_hit), 32'(mon_e.hit));
                end
                if (mon_e.chk_coll)
                    check("coll_status", 32'(coll_status), 32'(mon_e.coll));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock slot of stimulus; queues the expected response if any check requested.
    task automatic step(input logic we, input logic [AW-1:0] addr, input logic [7:0] data,
                        input logic fs, input logic d, input logic [HW-1:0] h,
                        input logic [HW-1:0] v, input logic [5:0] bg,
                        input logic cp, input logic [5:0] er, input logic eh,
                        input logic cc, input logic [NSPR-1:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        cfg_we      = we;
        cfg_addr    = addr;
        cfg_data    = data;
        frame_start = fs;
        de          = d;
        hpos        = h;
        vpos        = v;
        bg_rgb      = bg;
        drv_vld     = cp | cc;
        if (cp | cc) begin
            e = '{chk_pix: cp, rgb: er, hit: eh, chk_coll: cc, coll: ec};
            q.push_back(e);
        end
    endtask

    task automatic idle();
        step(0, '0, 8'h00, 0, 0, '0, '0, 6'h00, 0, 6'h00, 0, 0, '0);
    endtask

    task automatic wr(input logic [1:0] idx, input logic [3:0] off, input logic [7:0] d);
        step(1, {idx, off}, d, 0, 0, '0, '0, 6'h00, 0, 6'h00, 0, 0, '0);
    endtask

    task automatic fs();
        step(0, '0, 8'h00, 1, 0, '0, '0, 6'h00, 0, 6'h00, 0, 0, '0);
    endtask

    task automatic px(input int h, input int v, input logic [5:0] bg,
                      input logic [5:0] er, input logic eh);
        step(0, '0, 8'h00, 0, 1, HW'(h), HW'(v), bg, 1, er, eh, 0, '0);
    endtask

    task automatic pxc(input int h, input int v, input logic [5:0] bg,
                       input logic [5:0] er, input logic eh, input logic [NSPR-1:0] ec);
        step(0, '0, 8'h00, 0, 1, HW'(h), HW'(v), bg, 1, er, eh, 1, ec);
    endtask

    task automatic set_spr(input logic [1:0] idx, input int x, input int y,
                           input logic [7:0] colour, input logic [7:0] ctrl,
                           input logic [7:0] r0, input logic [7:0] r1);
        wr(idx, 4'd0, 8'(x));
        wr(idx, 4'd1, 8'(x >> 8));
        wr(idx, 4'd2, 8'(y));
        wr(idx, 4'd3, 8'(y >> 8));
        wr(idx, 4'd4, colour);
        wr(idx, 4'd5, ctrl);
        wr(idx, 4'd8, r0);
        wr(idx, 4'd9, r1);
        for (int r = 10; r < 16; r++) wr(idx, 4'(r), 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; drv_vld = 1'b0;
        cfg_we = 0; cfg_addr = '0; cfg_data = '0; frame_start = 0;
        de = 0; hpos = '0; vpos = '0; bg_rgb = '0;
        #1;
        check("reset_pix_rgb", 32'(pix_rgb), 32'h0);
        check("reset_pix_hit", 32'(pix_hit), 32'h0);
        check("reset_coll", 32'(coll_status), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Out of reset: no sprites, background passes, de=0 blanks.
        pxc(100, 50, 6'h0A, 6'h0A, 0, '0);
        step(0, '0, 8'h00, 0, 0, HW'(100), HW'(50), 6'h0A, 1, 6'h00, 0, 0, '0);

        // Single sprite, plain.
        set_spr(0, 100, 50, 8'h30, 8'h01, 8'h80, 8'h00);
        fs();
        px(100, 50, 6'h0A, 6'h30, 1);
        px(101, 50, 6'h0A, 6'h0A, 0);
        px(100, 51, 6'h0A, 6'h0A, 0);
        step(0, '0, 8'h00, 0, 0, HW'(100), HW'(50), 6'h15, 1, 6'h00, 0, 0, '0);

        // Horizontal flip.
        wr(0, 4'd5, 8'h03);
        fs();
        px(107, 50, 6'h0A, 6'h30, 1);
        px(100, 50, 6'h0A, 6'h0A, 0);

        // 2x scale, no flip.
        wr(0, 4'd5, 8'h05);
        fs();
        px(100, 50, 6'h0A, 6'h30, 1);
        px(101, 50, 6'h0A, 6'h30, 1);
        px(100, 51, 6'h0A, 6'h30, 1);
        px(101, 51, 6'h0A, 6'h30, 1);
        px(102, 50, 6'h0A, 6'h0A, 0);
        px(100, 52, 6'h0A, 6'h0A, 0);

        // Overlap: spr0 wins priority, collision flags next frame.
        set_spr(0, 100, 50, 8'h30, 8'h01, 8'hFF, 8'h00);
        set_spr(1, 104, 50, 8'h0C, 8'h01, 8'hFF, 8'h00);
        fs();
        pxc(104, 50, 6'h0A, 6'h30, 1, 3'b000);
        px(102, 50, 6'h0A, 6'h30, 1);
        px(110, 50, 6'h0A, 6'h0C, 1);
        px(104, 52, 6'h0A, 6'h0A, 0);
        fs();
        pxc(102, 50, 6'h0A, 6'h30, 1, 3'b011);
        // Overlap under de=0 must not count as a collision.
        step(0, '0, 8'h00, 0, 0, HW'(104), HW'(50), 6'h0A, 1, 6'h00, 0, 1, 3'b011);
        wr(1, 4'd0, 8'd200);
        fs();
        pxc(104, 50, 6'h0A, 6'h30, 1, 3'b000);
        pxc(200, 50, 6'h0A, 6'h0C, 1, 3'b000);

        // Write on the frame_start cycle: committed only at the next one.
        step(1, {2'd0, 4'd0}, 8'd120, 1, 0, '0, '0, 6'h00, 0, 6'h00, 0, 0, '0);
        px(100, 50, 6'h0A, 6'h30, 1);
        px(120, 50, 6'h0A, 6'h0A, 0);
        fs();
        px(120, 50, 6'h0A, 6'h30, 1);
        px(100, 50, 6'h0A, 6'h0A, 0);

        // Right-edge clipping at HW=10 with 2x scale; index 3 writes dropped.
        set_spr(0, 1020, 50, 8'h30, 8'h05, 8'hFF, 8'hFF);
        wr(1, 4'd5, 8'h00);
        wr(3, 4'd0, 8'h00);
        wr(3, 4'd1, 8'h00);
        wr(3, 4'd4, 8'h3F);
        fs();
        pxc(1019, 50, 6'h0A, 6'h0A, 0, 3'b000);
        for (int h = 1020; h < 1024; h++) px(h, 50, 6'h0A, 6'h30, 1);
        px(1023, 51, 6'h0A, 6'h30, 1);
        px(1020, 53, 6'h0A, 6'h30, 1);
        px(1020, 54, 6'h0A, 6'h0A, 0);
        px(0, 50, 6'h0A, 6'h0A, 0);
        px(4, 50, 6'h0A, 6'h0A, 0);
        px(11, 50, 6'h0A, 6'h0A, 0);

        // Build a collision, then reset asynchronously mid-stream.
        wr(1, 4'd0, 8'hFC);
        wr(1, 4'd1, 8'h03);
        wr(1, 4'd5, 8'h01);
        fs();
        px(1021, 50, 6'h0A, 6'h30, 1);
        fs();
        pxc(1022, 50, 6'h0A, 6'h30, 1, 3'b011);
        step(0, '0, 8'h00, 0, 1, HW'(1021), HW'(50), 6'h0A, 0, 6'h00, 0, 0, '0);
        step(0, '0, 8'h00, 0, 1, HW'(1021), HW'(50), 6'h0A, 0, 6'h00, 0, 0, '0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        drv_vld = 1'b0;
        #1;
        check("async_reset_pix_rgb", 32'(pix_rgb), 32'h0);
        check("async_reset_pix_hit", 32'(pix_hit), 32'h0);
        check("async_reset_coll", 32'(coll_status), 32'h0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // Sprites gone after reset: background shows at the old sprite spot.
        pxc(1021, 50, 6'h15, 6'h15, 0, 3'b000);
        step(0, '0, 8'h00, 0, 0, HW'(1021), HW'(50), 6'h15, 1, 6'h00, 0, 0, '0);

        for (int i = 0; i < 20 && q.size() != 0; i++) idle();
        repeat (3) idle();
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
